// File: rtl/vga_fb_arbiter_pkg.sv
// Shared definitions for the VGA framebuffer arbiter: geometry, bus widths and FSM encoding.
package vga_fb_pkg;

    localparam int H_VISIBLE = 640;
    localparam int V_VISIBLE = 480;
    localparam int ADDR_W    = 19;
    localparam int DATA_W    = 12;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_DISP_RD   = 3'd1;
    localparam logic [2:0] ST_DISP_WAIT = 3'd2;
    localparam logic [2:0] ST_CPU_WR    = 3'd3;
    localparam logic [2:0] ST_CPU_RD    = 3'd4;
    localparam logic [2:0] ST_CPU_WAIT  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_DISP_RD   = ST_DISP_RD,
        S_DISP_WAIT = ST_DISP_WAIT,
        S_CPU_WR    = ST_CPU_WR,
        S_CPU_RD    = ST_CPU_RD,
        S_CPU_WAIT  = ST_CPU_WAIT
    } state_e;

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// CPU request port and framebuffer RAM port of the arbiter, bundled as one bus.
import vga_fb_pkg::*;

interface vga_fb_arbiter_if #(
    parameter int AW = ADDR_W,
    parameter int DW = DATA_W
);
    // CPU: raise cpu_valid with cpu_we/cpu_addr/cpu_wdata and hold them all stable
    // until the one-cycle cpu_ready pulse; cpu_rdata is valid only in that cycle.
    logic          cpu_valid;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ready;
    logic [DW-1:0] cpu_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_valid, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ready, cpu_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_valid, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ready, cpu_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: display fetch has absolute priority over CPU access.
// Optional VGA_UNDERRUN_CNT_EN adds a saturating underrun event counter output.
module vga_fb_arbiter
    import vga_fb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              pixel_en,
    input  logic              pix_visible,
    input  logic              frame_start,
    output logic [DATA_W-1:0] rgb_out,
    output logic              underrun,
    input  logic              underrun_clr,
`ifdef VGA_UNDERRUN_CNT_EN
    output logic [15:0]       underrun_cnt,
`endif
    output state_e            dbg_state_o,
    vga_fb_arbiter_if.slave   bus
);

    state_e              state_q, state_d;
    logic                disp_req_q, disp_req_d;
    logic [ADDR_W-1:0]   disp_addr_q, disp_addr_d;
    logic [DATA_W-1:0]   rgb_q, rgb_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic                cpu_ready_q, cpu_ready_d;
    logic                underrun_q, underrun_d;
    logic                new_req;
    logic                underrun_evt;

    assign new_req      = pixel_en & pix_visible;
    // A fresh pixel while the previous one is still pending is dropped, not queued.
    assign underrun_evt = new_req & disp_req_q;

    always_comb begin
        state_d     = state_q;
        disp_req_d  = disp_req_q;
        disp_addr_d = disp_addr_q;
        rgb_d       = rgb_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_ready_d = 1'b0;
        underrun_d  = underrun_q;

        case (state_q)
            S_IDLE: begin
                if (disp_req_q | new_req) begin
                    state_d = S_DISP_RD;
                end else if (bus.cpu_valid & bus.cpu_we) begin
                    state_d = S_CPU_WR;
                end else if (bus.cpu_valid) begin
                    state_d = S_CPU_RD;
                end
            end
            S_DISP_RD: state_d = S_DISP_WAIT;
            S_DISP_WAIT: begin
                rgb_d       = bus.mem_rdata;
                disp_addr_d = disp_addr_q + ADDR_W'(1);
                state_d     = S_IDLE;
            end
            S_CPU_WR: begin
                cpu_ready_d = 1'b1;
                state_d     = S_IDLE;
            end
            S_CPU_RD: state_d = S_CPU_WAIT;
            S_CPU_WAIT: begin
                cpu_rdata_d = bus.mem_rdata;
                cpu_ready_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q == S_DISP_WAIT) begin
            disp_req_d = 1'b0;
        end else if (new_req) begin
            disp_req_d = 1'b1;
        end

        // Frame rewind overrides the post-fetch increment.
        if (frame_start) begin
            disp_addr_d = '0;
        end

        if (underrun_evt) begin
            underrun_d = 1'b1;
        end else if (underrun_clr) begin
            underrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            disp_req_q  <= 1'b0;
            disp_addr_q <= '0;
            rgb_q       <= '0;
            cpu_rdata_q <= '0;
            cpu_ready_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            disp_req_q  <= disp_req_d;
            disp_addr_q <= disp_addr_d;
            rgb_q       <= rgb_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_ready_q <= cpu_ready_d;
            underrun_q  <= underrun_d;
        end
    end

    // RAM strobes are a pure decode of the registered state.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (state_q)
            S_DISP_RD: begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = disp_addr_q;
            end
            S_CPU_WR: begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = bus.cpu_addr;
                bus.mem_wdata = bus.cpu_wdata;
            end
            S_CPU_RD: begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = bus.cpu_addr;
            end
            default: ;
        endcase
    end

    assign rgb_out       = rgb_q;
    assign underrun      = underrun_q;
    assign bus.cpu_ready = cpu_ready_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign dbg_state_o   = state_q;

`ifdef VGA_UNDERRUN_CNT_EN
    logic [15:0] ucnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ucnt_q <= '0;
        end else if (underrun_clr) begin
            ucnt_q <= underrun_evt ? 16'd1 : 16'd0;
        end else if (underrun_evt && (ucnt_q != 16'hFFFF)) begin
            ucnt_q <= ucnt_q + 16'd1;
        end
    end

    assign underrun_cnt = ucnt_q;
`endif

endmodule
